// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one variable-latency memory bus between instruction fetch and load/store.
// Latency: grant is combinational in IDLE, mem_req follows a cycle later, response pulses the cycle after mem_ack.
// Backpressure: requests wait for a grant, with no grant while busy; the bus stalls until mem_ack or the watchdog fires.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int BE_W  = DATA_W / 8;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t              state_q, state_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                drop_q, drop_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic                d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic idle, starved, tmo_expire, drop_now;

    assign idle       = (state_q == IDLE);
    assign starved    = (starve_q == STV_W'(STARVE_LIMIT));
    // Expiry on the TIMEOUT-th busy cycle, so mem_req is high for exactly TIMEOUT cycles.
    assign tmo_expire = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign drop_now   = drop_q | i_flush;

    // Grants are gated by reset so every output reads 0 while reset is held.
    assign i_gnt = reset & idle & i_req & ~i_flush & (~d_req | starved);
    assign d_gnt = reset & idle & d_req & ~(starved & i_req);

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        drop_d     = drop_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rvalid_d = 1'b0;
        i_err_d    = 1'b0;
        i_rdata_d  = '0;
        d_rvalid_d = 1'b0;
        d_err_d    = 1'b0;
        d_rdata_d  = '0;

        if (i_gnt || !i_req) begin
            starve_d = '0;
        end else if (d_gnt && !starved) begin
            starve_d = starve_q + STV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_gnt) begin
                    state_d = BUSY_I;
                    addr_d  = i_addr;
                    we_d    = 1'b0;
                    be_d    = '1;
                    wdata_d = '0;
                    tmo_d   = '0;
                    drop_d  = 1'b0;
                end else if (d_gnt) begin
                    state_d = BUSY_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    be_d    = d_be;
                    wdata_d = d_wdata;
                    tmo_d   = '0;
                end
            end
            BUSY_I: begin
                if (mem_ack || tmo_expire) begin
                    state_d    = IDLE;
                    drop_d     = 1'b0;
                    i_rvalid_d = ~drop_now;
                    i_err_d    = ~drop_now & ~mem_ack;
                    i_rdata_d  = (mem_ack && !drop_now) ? mem_rdata : '0;
                end else begin
                    tmo_d  = tmo_q + TMO_W'(1);
                    drop_d = drop_now;
                end
            end
            BUSY_D: begin
                if (mem_ack || tmo_expire) begin
                    state_d    = IDLE;
                    d_rvalid_d = 1'b1;
                    d_err_d    = ~mem_ack;
                    d_rdata_d  = (mem_ack && !we_q) ? mem_rdata : '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus fields read as zero whenever no transaction is on the bus.
        if (state_d == IDLE) begin
            we_d    = 1'b0;
            be_d    = '0;
            addr_d  = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            tmo_q      <= '0;
            drop_q     <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            drop_q     <= drop_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rvalid_q <= i_rvalid_d;
            i_err_q    <= i_err_d;
            i_rdata_q  <= i_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_req   = ~idle;
    assign busy      = ~idle;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: arbitration vector table, directed multi-cycle sequences,
// and a randomized run scored against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_flush, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be, mem_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; i_flush = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    typedef struct {
        logic ir, dr, fl;
        logic eig, edg;
    } arb_vec_t;

    arb_vec_t vt[7];

    // Randomized-run model state
    int          owner, starve, lat, hi;
    bit          drop, i_took, d_took, exp_ig, exp_dg;
    bit          exp_irv, exp_drv, n_irv, n_drv;
    logic [31:0] exp_ird, exp_drd, n_ird, n_drd, cur_addr, cur_wd;
    bit          cur_we;
    logic [3:0]  cur_be;
    logic [9:0]  exp_order;

    initial begin
        vt[0] = '{0, 0, 0, 0, 0};
        vt[1] = '{1, 0, 0, 1, 0};
        vt[2] = '{0, 1, 0, 0, 1};
        vt[3] = '{1, 1, 0, 0, 1};
        vt[4] = '{1, 0, 1, 0, 0};
        vt[5] = '{0, 1, 1, 0, 1};
        vt[6] = '{1, 1, 1, 0, 1};

        // Reset state, with requests already asserted
        reset = 0;
        idle_inputs();
        i_req = 1; d_req = 1;
        #2;
        chk("rst_i_gnt", i_gnt, 0);   chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_req", mem_req, 0); chk("rst_busy", busy, 0);
        chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        reset = 1;

        // Single fetch, ack on the third bus cycle
        i_req = 1; i_addr = 32'h3000;
        @(negedge clk);
        chk("sf_i_gnt", i_gnt, 1); chk("sf_d_gnt", d_gnt, 0);
        tick(); i_req = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin mem_ack = 1; mem_rdata = 32'h24080005; end
            @(negedge clk);
            chk($sformatf("sf_mem_req_c%0d", c), mem_req, 1);
            chk($sformatf("sf_mem_addr_c%0d", c), mem_addr, 32'h3000);
            chk($sformatf("sf_i_rvalid_c%0d", c), i_rvalid, 0);
            tick();
        end
        mem_ack = 0;
        @(negedge clk);
        chk("sf_i_rvalid", i_rvalid, 1); chk("sf_i_rdata", i_rdata, 32'h24080005);
        chk("sf_i_err", i_err, 0); chk("sf_d_rvalid", d_rvalid, 0); chk("sf_mem_req_off", mem_req, 0);
        tick();
        chk("sf_pulse_end", i_rvalid, 0);

        // Combinational arbitration table from IDLE with starve count at zero
        for (int k = 0; k < 7; k++) begin
            i_req = vt[k].ir; d_req = vt[k].dr; i_flush = vt[k].fl;
            #2;
            chk($sformatf("tab%0d_i_gnt", k), i_gnt, vt[k].eig);
            chk($sformatf("tab%0d_d_gnt", k), d_gnt, vt[k].edg);
            idle_inputs();
            tick();
        end

        // Store forwarding and zero read data
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h10; d_wdata = 32'hABCD1234;
        @(negedge clk);
        chk("st_d_gnt", d_gnt, 1);
        tick(); idle_inputs();
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("st_mem_req", mem_req, 1); chk("st_mem_we", mem_we, 1); chk("st_mem_be", mem_be, 4'b0011);
        chk("st_mem_addr", mem_addr, 32'h10); chk("st_mem_wdata", mem_wdata, 32'hABCD1234);
        tick(); mem_ack = 0;
        @(negedge clk);
        chk("st_d_rvalid", d_rvalid, 1); chk("st_d_rdata", d_rdata, 0); chk("st_i_rvalid", i_rvalid, 0);
        tick();

        // Flush during an in-flight fetch
        i_req = 1; i_addr = 32'h40;
        @(negedge clk);
        chk("fl_i_gnt", i_gnt, 1);
        tick(); i_req = 0; i_flush = 1;
        @(negedge clk);
        chk("fl_mem_req1", mem_req, 1);
        tick(); i_flush = 0; mem_ack = 1; mem_rdata = 32'h11111111; d_req = 1; d_addr = 32'h44;
        @(negedge clk);
        chk("fl_mem_req2", mem_req, 1); chk("fl_no_dgnt_busy", d_gnt, 0);
        tick(); mem_ack = 0;
        @(negedge clk);
        chk("fl_i_rvalid", i_rvalid, 0); chk("fl_i_err", i_err, 0);
        chk("fl_d_gnt_after", d_gnt, 1); chk("fl_mem_req_off", mem_req, 0);
        tick(); d_req = 0; mem_ack = 1; mem_rdata = 32'h55;
        @(negedge clk);
        chk("fl_d_mem_addr", mem_addr, 32'h44);
        tick(); mem_ack = 0;
        @(negedge clk);
        chk("fl_d_rvalid", d_rvalid, 1); chk("fl_d_rdata", d_rdata, 32'h55); chk("fl_i_rvalid2", i_rvalid, 0);
        tick();

        // Starvation guard: both requesting, 1-cycle acks
        i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200;
        exp_order = 10'b1000010000;
        begin
            int g = 0;
            int cyc = 0;
            while (g < 10 && cyc < 60) begin
                @(negedge clk);
                if (i_gnt || d_gnt) begin
                    chk($sformatf("order%0d_is_fetch", g), i_gnt, exp_order[g]);
                    g++;
                end
                tick();
                mem_ack = mem_req;
                cyc++;
            end
            chk("order_grants_seen", g, 10);
        end
        i_req = 0; d_req = 0; mem_ack = mem_req;
        repeat (3) begin tick(); mem_ack = mem_req; end
        idle_inputs();
        tick();

        // Watchdog on a data load with no ack
        d_req = 1; d_addr = 32'h80; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("to_d_gnt", d_gnt, 1);
        tick(); d_req = 0;
        hi = 0;
        while (mem_req && hi < 400) begin hi++; tick(); end
        chk("to_busy_cycles", hi, 255);
        @(negedge clk);
        chk("to_d_rvalid", d_rvalid, 1); chk("to_d_err", d_err, 1);
        chk("to_d_rdata", d_rdata, 0); chk("to_busy", busy, 0); chk("to_i_rvalid", i_rvalid, 0);
        tick();
        chk("to_pulse_end", d_rvalid | d_err, 0);

        // Ack on the same cycle the watchdog would fire
        d_req = 1; d_addr = 32'h84;
        @(negedge clk);
        chk("tc_d_gnt", d_gnt, 1);
        tick(); d_req = 0;
        repeat (254) tick();
        mem_ack = 1; mem_rdata = 32'h1234;
        @(negedge clk);
        chk("tc_mem_req", mem_req, 1);
        tick(); mem_ack = 0;
        chk("tc_d_rvalid", d_rvalid, 1); chk("tc_d_err", d_err, 0); chk("tc_d_rdata", d_rdata, 32'h1234);
        tick();

        // Async reset mid BUSY_D after the starve count reached its limit
        i_req = 1; d_req = 1; i_addr = 32'h500; d_addr = 32'h600;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ar_pre_d_gnt%0d", k), d_gnt, 1);
            tick();
            if (k < 3) begin mem_ack = 1; tick(); mem_ack = 0; end
        end
        #2 reset = 0;
        #1;
        chk("ar_mem_req", mem_req, 0); chk("ar_busy", busy, 0);
        chk("ar_i_gnt", i_gnt, 0); chk("ar_d_gnt", d_gnt, 0);
        chk("ar_d_rvalid", d_rvalid, 0); chk("ar_i_rvalid", i_rvalid, 0);
        tick();
        chk("ar_hold_mem_req", mem_req, 0);
        reset = 1;
        #2;
        chk("ar_after_d_gnt", d_gnt, 1); chk("ar_after_i_gnt0", i_gnt, 0);
        d_req = 0;
        #1;
        chk("ar_after_i_gnt", i_gnt, 1);
        tick(); i_req = 0; mem_ack = 1;
        tick(); mem_ack = 0;
        tick();

        // Randomized run against a transaction-level model
        reset = 0; idle_inputs();
        tick(); reset = 1;
        owner = 0; starve = 0; drop = 0; lat = 0;
        i_took = 0; d_took = 0;
        exp_irv = 0; exp_drv = 0; exp_ird = 0; exp_drd = 0;
        cur_addr = 0; cur_we = 0; cur_be = 0; cur_wd = 0;
        for (int c = 0; c < 800; c++) begin
            if (!i_req || i_took) begin
                i_req = ($urandom % 2) == 1; i_addr = $urandom;
            end
            if (!d_req || d_took) begin
                d_req = ($urandom % 2) == 1; d_we = ($urandom % 2) == 1;
                d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
            end
            i_took = 0; d_took = 0;
            i_flush = ($urandom % 6) == 0;
            mem_ack = (owner != 0) && (lat == 0);
            if (owner != 0 && lat > 0) lat--;
            mem_rdata = $urandom;
            @(negedge clk);

            exp_ig = (owner == 0) && i_req && !i_flush && (!d_req || starve == LIMIT);
            exp_dg = (owner == 0) && d_req && !(starve == LIMIT && i_req);
            chk($sformatf("r%0d_i_gnt", c), i_gnt, exp_ig);
            chk($sformatf("r%0d_d_gnt", c), d_gnt, exp_dg);
            chk($sformatf("r%0d_mem_req", c), mem_req, owner != 0);
            chk($sformatf("r%0d_busy", c), busy, owner != 0);
            if (owner != 0) begin
                chk($sformatf("r%0d_mem_addr", c), mem_addr, cur_addr);
                chk($sformatf("r%0d_mem_we", c), mem_we, cur_we);
                if (owner == 2) chk($sformatf("r%0d_mem_be", c), mem_be, cur_be);
                if (cur_we) chk($sformatf("r%0d_mem_wdata", c), mem_wdata, cur_wd);
            end
            chk($sformatf("r%0d_i_rvalid", c), i_rvalid, exp_irv);
            chk($sformatf("r%0d_d_rvalid", c), d_rvalid, exp_drv);
            chk($sformatf("r%0d_i_rdata", c), i_rdata, exp_ird);
            chk($sformatf("r%0d_d_rdata", c), d_rdata, exp_drd);
            chk($sformatf("r%0d_errs", c), {i_err, d_err}, 2'b00);

            n_irv = 0; n_drv = 0; n_ird = 0; n_drd = 0;
            if (owner == 1) begin
                if (i_flush) drop = 1;
                if (mem_ack) begin
                    if (!drop) begin n_irv = 1; n_ird = mem_rdata; end
                    owner = 0; drop = 0;
                end
            end else if (owner == 2 && mem_ack) begin
                n_drv = 1; n_drd = cur_we ? 32'h0 : mem_rdata;
                owner = 0;
            end
            if (exp_ig || !i_req) starve = 0;
            else if (exp_dg && starve < LIMIT) starve++;
            if (exp_ig) begin
                owner = 1; drop = 0; cur_addr = i_addr; cur_we = 0; lat = $urandom % 4; i_took = 1;
            end
            if (exp_dg) begin
                owner = 2; cur_addr = d_addr; cur_we = d_we; cur_be = d_be; cur_wd = d_wdata;
                lat = $urandom % 4; d_took = 1;
            end
            exp_irv = n_irv; exp_ird = n_ird; exp_drv = n_drv; exp_drd = n_drd;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
